// File: rtl/fx_sub_pipe.sv
// Pipelined signed fixed-point subtractor: o_data = i_data_1 - i_data_2 with
// fraction alignment, saturate/wrap range fitting and a DELAY-cycle valid pipeline.
module fx_sub_pipe #(
  parameter int IN_W     = 12,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 13,
  parameter int OUT_FRAC = 8,
  parameter int DELAY    = 2,   // legal range 1..8
  parameter int SAT      = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data_1,
  input  logic [IN_W-1:0]  i_data_2,
  input  logic             i_clr_ovf,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  output logic             o_ovf,
  output logic             o_ovf_sticky
);

  localparam int DW   = IN_W + 1;
  localparam int LSH  = (OUT_FRAC > IN_FRAC) ? OUT_FRAC - IN_FRAC : 0;
  localparam int RSH  = (IN_FRAC > OUT_FRAC) ? IN_FRAC - OUT_FRAC : 0;
  localparam int AW   = DW + LSH;
  // Working width always has at least one bit of headroom above OUT_W,
  // so the fit test below is uniform regardless of the parameter mix.
  localparam int EW   = ((AW > OUT_W) ? AW : OUT_W) + 1;
  localparam int LAST = DELAY - 1;

  logic signed [DW-1:0]   diff;
  logic signed [EW-1:0]   ext;
  logic signed [EW-1:0]   aligned;
  logic [EW-OUT_W:0]      upper;
  logic                   fits;
  logic [OUT_W-1:0]       fit_data;
  logic                   fit_ovf;

  logic [OUT_W-1:0]       data_q [DELAY];
  logic [OUT_W-1:0]       data_d [DELAY];
  logic [DELAY-1:0]       vld_q;
  logic [DELAY-1:0]       vld_d;
  logic [DELAY-1:0]       ovf_q;
  logic [DELAY-1:0]       ovf_d;
  logic                   sticky_q;
  logic                   sticky_d;

  always_comb begin
    diff    = $signed({i_data_1[IN_W-1], i_data_1}) - $signed({i_data_2[IN_W-1], i_data_2});
    ext     = {{(EW-DW){diff[DW-1]}}, diff};
    aligned = (ext <<< LSH) >>> RSH;
    // Value fits OUT_W when every bit from the output sign bit upward agrees.
    upper   = aligned[EW-1:OUT_W-1];
    fits    = (&upper) | ~(|upper);
    fit_ovf = ~fits;
    if (fits) begin
      fit_data = aligned[OUT_W-1:0];
    end else if (SAT != 0) begin
      fit_data = aligned[EW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      fit_data = aligned[OUT_W-1:0];
    end
  end

  always_comb begin
    vld_d[0]  = i_valid;
    ovf_d[0]  = i_valid ? fit_ovf : ovf_q[0];
    data_d[0] = i_valid ? fit_data : data_q[0];
    for (int k = 1; k < DELAY; k++) begin
      vld_d[k]  = vld_q[k-1];
      ovf_d[k]  = vld_q[k-1] ? ovf_q[k-1] : ovf_q[k];
      data_d[k] = vld_q[k-1] ? data_q[k-1] : data_q[k];
    end
  end

  // Sticky rises in the same cycle an overflowing sample is emitted, and an
  // emitted overflow (current or arriving) always beats a coincident clear.
  always_comb begin
    sticky_d = sticky_q;
    if (i_clr_ovf) begin
      sticky_d = 1'b0;
    end
    if ((vld_q[LAST] & ovf_q[LAST]) | (vld_d[LAST] & ovf_d[LAST])) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q    <= '0;
      ovf_q    <= '0;
      sticky_q <= 1'b0;
      for (int k = 0; k < DELAY; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      for (int k = 0; k < DELAY; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign o_data       = data_q[LAST];
  assign o_valid      = vld_q[LAST];
  assign o_ovf        = ovf_q[LAST];
  assign o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fx_sub_pipe.sv
// Bench for fx_sub_pipe: four parameterisations share one stimulus stream,
// each with its own expected-result queue.
module tb_fx_sub_pipe;

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic        clr;
  logic [11:0] d1;
  logic [11:0] d2;

  always #5 clk = ~clk;

  logic [12:0] a_data;
  logic        a_vld, a_ovf, a_stk;
  logic [11:0] b_data;
  logic        b_vld, b_ovf, b_stk;
  logic [11:0] c_data;
  logic        c_vld, c_ovf, c_stk;
  logic [12:0] d_data;
  logic        d_vld, d_ovf, d_stk;

  fx_sub_pipe #(.IN_W(12), .IN_FRAC(8), .OUT_W(13), .OUT_FRAC(8), .DELAY(2), .SAT(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_data_1(d1), .i_data_2(d2),
    .i_clr_ovf(clr), .o_data(a_data), .o_valid(a_vld), .o_ovf(a_ovf), .o_ovf_sticky(a_stk));
  fx_sub_pipe #(.IN_W(12), .IN_FRAC(8), .OUT_W(12), .OUT_FRAC(8), .DELAY(2), .SAT(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_data_1(d1), .i_data_2(d2),
    .i_clr_ovf(clr), .o_data(b_data), .o_valid(b_vld), .o_ovf(b_ovf), .o_ovf_sticky(b_stk));
  fx_sub_pipe #(.IN_W(12), .IN_FRAC(8), .OUT_W(12), .OUT_FRAC(8), .DELAY(2), .SAT(0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_data_1(d1), .i_data_2(d2),
    .i_clr_ovf(clr), .o_data(c_data), .o_valid(c_vld), .o_ovf(c_ovf), .o_ovf_sticky(c_stk));
  fx_sub_pipe #(.IN_W(12), .IN_FRAC(8), .OUT_W(13), .OUT_FRAC(6), .DELAY(2), .SAT(1)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_data_1(d1), .i_data_2(d2),
    .i_clr_ovf(clr), .o_data(d_data), .o_valid(d_vld), .o_ovf(d_ovf), .o_ovf_sticky(d_stk));

  logic [15:0] od [4];
  logic        ov [4];
  logic        oo [4];
  logic        os [4];

  assign od[0] = {3'b000, a_data};
  assign od[1] = {4'b0000, b_data};
  assign od[2] = {4'b0000, c_data};
  assign od[3] = {3'b000, d_data};
  assign ov[0] = a_vld;  assign ov[1] = b_vld;  assign ov[2] = c_vld;  assign ov[3] = d_vld;
  assign oo[0] = a_ovf;  assign oo[1] = b_ovf;  assign oo[2] = c_ovf;  assign oo[3] = d_ovf;
  assign os[0] = a_stk;  assign os[1] = b_stk;  assign os[2] = c_stk;  assign os[3] = d_stk;

  int ow_tab  [4] = '{13, 12, 12, 13};
  int of_tab  [4] = '{8, 8, 8, 6};
  int sat_tab [4] = '{1, 1, 0, 1};

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t qd[$];
  exp_t cur [4];
  logic [1:0] vhist;
  logic       exp_vld;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic exp_t model(input int i, input logic [11:0] x, input logic [11:0] y);
    exp_t e;
    int xi, yi, dv, mx, mn;
    xi = $signed(x);
    yi = $signed(y);
    dv = xi - yi;
    if (of_tab[i] < 8) dv = dv >>> (8 - of_tab[i]);
    else               dv = dv <<< (of_tab[i] - 8);
    mx = (1 << (ow_tab[i] - 1)) - 1;
    mn = -(1 << (ow_tab[i] - 1));
    e.ovf = (dv > mx) || (dv < mn);
    if (e.ovf && sat_tab[i] != 0) dv = (dv > mx) ? mx : mn;
    e.data = 16'(dv & ((1 << ow_tab[i]) - 1));
    return e;
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete(); qc.delete(); qd.delete();
    for (int i = 0; i < 4; i++) cur[i] = '0;
    vhist   = 2'b00;
    exp_vld = 1'b0;
  endtask

  // Drive one cycle, push expectations for an accepted sample, pop the one due out.
  task automatic tick(input logic v, input logic [11:0] x, input logic [11:0] y, input logic c);
    vld = v; d1 = x; d2 = y; clr = c;
    @(posedge clk);
    if (v) begin
      qa.push_back(model(0, x, y));
      qb.push_back(model(1, x, y));
      qc.push_back(model(2, x, y));
      qd.push_back(model(3, x, y));
    end
    vhist   = {vhist[0], v};
    exp_vld = vhist[1];
    if (exp_vld) begin
      if (qa.size() > 0) cur[0] = qa.pop_front();
      if (qb.size() > 0) cur[1] = qb.pop_front();
      if (qc.size() > 0) cur[2] = qc.pop_front();
      if (qd.size() > 0) cur[3] = qd.pop_front();
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vld = 1'b0; clr = 1'b0; d1 = '0; d2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (ov[i] !== 1'b0 || od[i] !== 16'h0 || oo[i] !== 1'b0 || os[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset inst%0d: got vld=%b data=%h ovf=%b stk=%b, expected all zero",
                 i, ov[i], od[i], oo[i], os[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick(1'b0, 12'h000, 12'h000, 1'b0);
      n_tests++;
      if (a_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: got o_valid=%b, expected 0", a_vld);
      end
    end
  endtask

  task automatic test_basic();
    logic [11:0] xs [3] = '{12'h100, 12'h000, 12'h000};
    logic [11:0] ys [3] = '{12'h080, 12'h000, 12'h000};
    logic        vs [3] = '{1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 3; t++) begin
      tick(vs[t], xs[t], ys[t], 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (ov[i] !== exp_vld || od[i] !== cur[i].data || oo[i] !== cur[i].ovf) begin
          n_fail++;
          $display("FAIL basic inst%0d cyc%0d: got vld=%b data=%h ovf=%b, expected vld=%b data=%h ovf=%b",
                   i, t, ov[i], od[i], oo[i], exp_vld, cur[i].data, cur[i].ovf);
        end
      end
      if (t == 1) begin
        n_tests++;
        if (a_vld !== 1'b1 || a_data !== 13'h0080 || a_ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_latency: got vld=%b data=%h ovf=%b, expected vld=1 data=0080 ovf=0",
                   a_vld, a_data, a_ovf);
        end
      end
    end
  endtask

  task automatic test_extremes();
    n_tests++;
    if (b_stk !== 1'b0) begin
      n_fail++;
      $display("FAIL extremes_stk_pre: got sticky=%b, expected 0", b_stk);
    end
    tick(1'b1, 12'h800, 12'h7FF, 1'b0);
    tick(1'b0, 12'h000, 12'h000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (ov[i] !== exp_vld || od[i] !== cur[i].data || oo[i] !== cur[i].ovf) begin
        n_fail++;
        $display("FAIL extremes inst%0d: got vld=%b data=%h ovf=%b, expected vld=%b data=%h ovf=%b",
                 i, ov[i], od[i], oo[i], exp_vld, cur[i].data, cur[i].ovf);
      end
    end
    n_tests++;
    if (a_data !== 13'h1001 || a_ovf !== 1'b0 || a_stk !== 1'b0) begin
      n_fail++;
      $display("FAIL extremes_wide: got data=%h ovf=%b stk=%b, expected 1001 0 0", a_data, a_ovf, a_stk);
    end
    n_tests++;
    if (b_vld !== 1'b1 || b_data !== 12'h800 || b_ovf !== 1'b1 || b_stk !== 1'b1) begin
      n_fail++;
      $display("FAIL extremes_sat: got vld=%b data=%h ovf=%b stk=%b, expected 1 800 1 1",
               b_vld, b_data, b_ovf, b_stk);
    end
    n_tests++;
    if (c_data !== 12'h001 || c_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL extremes_wrap: got data=%h ovf=%b, expected 001 1", c_data, c_ovf);
    end
    tick(1'b0, 12'h000, 12'h000, 1'b0);
  endtask

  task automatic test_sticky();
    tick(1'b1, 12'h800, 12'h7FF, 1'b0);
    tick(1'b0, 12'h000, 12'h000, 1'b0);
    n_tests++;
    if (b_vld !== 1'b1 || b_ovf !== 1'b1 || b_stk !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_second: got vld=%b ovf=%b stk=%b, expected 1 1 1", b_vld, b_ovf, b_stk);
    end
    tick(1'b0, 12'h000, 12'h000, 1'b1);
    n_tests++;
    if (b_stk !== 1'b1 || c_stk !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set_wins: got stk_b=%b stk_c=%b, expected 1 1", b_stk, c_stk);
    end
    tick(1'b0, 12'h000, 12'h000, 1'b1);
    n_tests++;
    if (b_stk !== 1'b0 || c_stk !== 1'b0 || a_stk !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear: got stk_a=%b stk_b=%b stk_c=%b, expected 0 0 0", a_stk, b_stk, c_stk);
    end
    tick(1'b0, 12'h000, 12'h000, 1'b0);
    n_tests++;
    if (b_stk !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_stays_clear: got stk=%b, expected 0", b_stk);
    end
  endtask

  task automatic test_frac();
    logic [11:0] xs [4] = '{12'h003, 12'hFFF, 12'h000, 12'h000};
    logic        vs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 4; t++) begin
      tick(vs[t], xs[t], 12'h000, 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (ov[i] !== exp_vld || od[i] !== cur[i].data || oo[i] !== cur[i].ovf) begin
          n_fail++;
          $display("FAIL frac inst%0d cyc%0d: got vld=%b data=%h ovf=%b, expected vld=%b data=%h ovf=%b",
                   i, t, ov[i], od[i], oo[i], exp_vld, cur[i].data, cur[i].ovf);
        end
      end
      if (t == 1) begin
        n_tests++;
        if (d_vld !== 1'b1 || d_data !== 13'h0000) begin
          n_fail++;
          $display("FAIL frac_small: got vld=%b data=%h, expected 1 0000", d_vld, d_data);
        end
      end
      if (t == 2) begin
        n_tests++;
        if (d_vld !== 1'b1 || d_data !== 13'h1FFF || d_ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL frac_floor: got vld=%b data=%h ovf=%b, expected 1 1FFF 0", d_vld, d_data, d_ovf);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        vs [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [11:0] xs [7] = '{12'h123, 12'h777, 12'h7FF, 12'h801, 12'h000, 12'h000, 12'h000};
    logic [11:0] ys [7] = '{12'h045, 12'h111, 12'h001, 12'h010, 12'h000, 12'h000, 12'h000};
    for (int t = 0; t < 7; t++) begin
      tick(vs[t], xs[t], ys[t], 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (ov[i] !== exp_vld || od[i] !== cur[i].data || oo[i] !== cur[i].ovf) begin
          n_fail++;
          $display("FAIL b2b inst%0d cyc%0d: got vld=%b data=%h ovf=%b, expected vld=%b data=%h ovf=%b",
                   i, t, ov[i], od[i], oo[i], exp_vld, cur[i].data, cur[i].ovf);
        end
      end
      if (t == 2) begin
        n_tests++;
        if (a_vld !== 1'b0 || a_data !== 13'h00DE) begin
          n_fail++;
          $display("FAIL b2b_bubble_hold: got vld=%b data=%h, expected 0 00DE", a_vld, a_data);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    tick(1'b1, 12'h200, 12'h010, 1'b0);
    tick(1'b1, 12'h300, 12'h020, 1'b0);
    n_tests++;
    if (a_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: got vld=%b, expected 1", a_vld);
    end
    #2;
    vld   = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (ov[i] !== 1'b0 || od[i] !== 16'h0 || oo[i] !== 1'b0 || os[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_async inst%0d: got vld=%b data=%h ovf=%b stk=%b, expected all zero",
                 i, ov[i], od[i], oo[i], os[i]);
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick(1'b0, 12'h000, 12'h000, 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (ov[i] !== 1'b0 || od[i] !== 16'h0) begin
          n_fail++;
          $display("FAIL midreset_stale inst%0d cyc%0d: got vld=%b data=%h, expected 0 0000",
                   i, t, ov[i], od[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_sticky();
    test_frac();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
